// File: rtl/hpdcache_flush_walker_pkg.sv
// Shared types for the whole-cache flush walker: FSM encoding and nline width helper.
package hpdcache_flush_walker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        ISSUE,
        DRAIN
    } hpdcache_flush_walker_fsm_e;

    function automatic int hpdcache_flush_walker_nlw(input int tag_width, input int nsets);
        return tag_width + $clog2(nsets);
    endfunction

endpackage

// File: rtl/hpdcache_flush_walker_prio.sv
// Lowest-index one-hot selector: keeps only the least significant set bit of val_i.
module hpdcache_prio_1hot_encoder #(
    parameter int N = 8
) (
    input  logic [N-1:0] val_i,
    output logic [N-1:0] val_o
);

    // Two's-complement trick isolates the lowest set bit; all-zero input gives all-zero output.
    assign val_o = val_i & (~val_i + N'(1));

endmodule

// File: rtl/hpdcache_flush_walker.sv
// Whole-cache flush sequencer: walks every directory set and hands dirty lines to the flush controller.
// Optional HPDCACHE_FLUSH_WALKER_INVAL_EN also invalidates every valid line while walking.
//
// state | meaning
// IDLE  | waiting for start_i, start_ready_o high
// READ  | directory read of set_q requested, waiting for grant
// LOAD  | tags and dirty/valid vector of set_q captured
// ISSUE | one alloc (or invalidate) per cycle until pend_q is empty
// DRAIN | walk finished, waiting for flush controller to go empty
module hpdcache_flush_walker
    import hpdcache_flush_walker_pkg::*;
#(
    parameter  int NSETS     = 64,
    parameter  int NWAYS     = 8,
    parameter  int TAG_WIDTH = 28,
    localparam int SETW      = $clog2(NSETS),
    localparam int NLW       = hpdcache_flush_walker_nlw(TAG_WIDTH, NSETS)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    output logic                         start_ready_o,
    output logic                         done_o,
    output logic                         dir_rd_o,
    input  logic                         dir_gnt_i,
    output logic [SETW-1:0]              dir_rd_set_o,
    input  logic [NWAYS*TAG_WIDTH-1:0]   dir_rd_tags_i,
    input  logic [NWAYS-1:0]             dir_rd_dirty_i,
`ifdef HPDCACHE_FLUSH_WALKER_INVAL_EN
    input  logic [NWAYS-1:0]             dir_rd_valid_i,
    output logic                         dir_inval_o,
`endif
    output logic                         dir_clr_o,
    output logic [SETW-1:0]              dir_clr_set_o,
    output logic [NWAYS-1:0]             dir_clr_way_o,
    output logic                         flush_alloc_o,
    input  logic                         flush_alloc_ready_i,
    output logic [NLW-1:0]               flush_alloc_nline_o,
    output logic [NWAYS-1:0]             flush_alloc_way_o,
    input  logic                         flush_empty_i
);

    hpdcache_flush_walker_fsm_e           state_q;
    logic [SETW-1:0]                      set_q;
    logic [NWAYS-1:0]                     pend_q;
    logic [NWAYS-1:0][TAG_WIDTH-1:0]      tags_q;

    logic [NWAYS-1:0]                     load_vec;
    logic [NWAYS-1:0]                     dirty_pend;
    logic [NWAYS-1:0]                     sel_in;
    logic [NWAYS-1:0]                     sel;
    logic [TAG_WIDTH-1:0]                 sel_tag;
    logic                                 in_issue;
    logic                                 alloc_hs;
    logic                                 consume;

`ifdef HPDCACHE_FLUSH_WALKER_INVAL_EN
    logic [NWAYS-1:0]                     dirty_q;
    logic                                 clean_inval;

    // pend_q tracks every valid way; dirty ones are drained first so allocs never wait behind invalidates.
    assign load_vec    = dir_rd_valid_i | dir_rd_dirty_i;
    assign dirty_pend  = pend_q & dirty_q;
    assign clean_inval = in_issue & ~(|dirty_pend) & (|pend_q);
    assign consume     = alloc_hs | clean_inval;
    assign dir_inval_o = consume;
`else
    assign load_vec    = dir_rd_dirty_i;
    assign dirty_pend  = pend_q;
    assign consume     = alloc_hs;
`endif

    assign sel_in = (|dirty_pend) ? dirty_pend : pend_q;

    hpdcache_prio_1hot_encoder #(
        .N (NWAYS)
    ) u_sel (
        .val_i (sel_in),
        .val_o (sel)
    );

    always_comb begin
        sel_tag = '0;
        for (int w = 0; w < NWAYS; w++) begin
            if (sel[w]) begin
                sel_tag = sel_tag | tags_q[w];
            end
        end
    end

    assign in_issue            = (state_q == ISSUE);
    assign flush_alloc_o       = in_issue & (|dirty_pend);
    assign alloc_hs            = flush_alloc_o & flush_alloc_ready_i;
    assign flush_alloc_nline_o = flush_alloc_o ? {sel_tag, set_q} : '0;
    assign flush_alloc_way_o   = flush_alloc_o ? sel : '0;

    assign dir_clr_o     = alloc_hs;
    assign dir_clr_set_o = set_q;
    assign dir_clr_way_o = consume ? sel : '0;

    assign dir_rd_o      = (state_q == READ);
    assign dir_rd_set_o  = set_q;
    assign start_ready_o = (state_q == IDLE);
    assign done_o        = (state_q == DRAIN) & flush_empty_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            set_q   <= '0;
            pend_q  <= '0;
            tags_q  <= '0;
`ifdef HPDCACHE_FLUSH_WALKER_INVAL_EN
            dirty_q <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        set_q   <= '0;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (dir_gnt_i) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    pend_q  <= load_vec;
                    tags_q  <= dir_rd_tags_i;
`ifdef HPDCACHE_FLUSH_WALKER_INVAL_EN
                    dirty_q <= dir_rd_dirty_i;
`endif
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    if (|pend_q) begin
                        if (consume) begin
                            pend_q <= pend_q & ~sel;
                        end
                    end else if (set_q == SETW'(NSETS - 1)) begin
                        state_q <= DRAIN;
                    end else begin
                        set_q   <= set_q + 1'b1;
                        state_q <= READ;
                    end
                end
                DRAIN: begin
                    if (flush_empty_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hpdcache_flush_walker.sv
// Self-checking bench for hpdcache_flush_walker: directed vector table, reset abort and randomized walks
// against a directory model and an expected-alloc list built from the directory contents.
module tb_hpdcache_flush_walker;

    localparam int NSETS     = 64;
    localparam int NWAYS     = 8;
    localparam int TAG_WIDTH = 28;
    localparam int SETW      = 6;
    localparam int NLW       = 34;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                       rst_ni;
    logic                       start_i;
    logic                       start_ready_o;
    logic                       done_o;
    logic                       dir_rd_o;
    logic                       dir_gnt_i;
    logic [SETW-1:0]            dir_rd_set_o;
    logic [NWAYS*TAG_WIDTH-1:0] dir_rd_tags_i;
    logic [NWAYS-1:0]           dir_rd_dirty_i;
    logic                       dir_clr_o;
    logic [SETW-1:0]            dir_clr_set_o;
    logic [NWAYS-1:0]           dir_clr_way_o;
    logic                       flush_alloc_o;
    logic                       flush_alloc_ready_i;
    logic [NLW-1:0]             flush_alloc_nline_o;
    logic [NWAYS-1:0]           flush_alloc_way_o;
    logic                       flush_empty_i;
`ifdef HPDCACHE_FLUSH_WALKER_INVAL_EN
    logic [NWAYS-1:0]           dir_rd_valid_i;
    logic                       dir_inval_o;
`endif

    hpdcache_flush_walker #(
        .NSETS     (NSETS),
        .NWAYS     (NWAYS),
        .TAG_WIDTH (TAG_WIDTH)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .start_i             (start_i),
        .start_ready_o       (start_ready_o),
        .done_o              (done_o),
        .dir_rd_o            (dir_rd_o),
        .dir_gnt_i           (dir_gnt_i),
        .dir_rd_set_o        (dir_rd_set_o),
        .dir_rd_tags_i       (dir_rd_tags_i),
        .dir_rd_dirty_i      (dir_rd_dirty_i),
`ifdef HPDCACHE_FLUSH_WALKER_INVAL_EN
        .dir_rd_valid_i      (dir_rd_valid_i),
        .dir_inval_o         (dir_inval_o),
`endif
        .dir_clr_o           (dir_clr_o),
        .dir_clr_set_o       (dir_clr_set_o),
        .dir_clr_way_o       (dir_clr_way_o),
        .flush_alloc_o       (flush_alloc_o),
        .flush_alloc_ready_i (flush_alloc_ready_i),
        .flush_alloc_nline_o (flush_alloc_nline_o),
        .flush_alloc_way_o   (flush_alloc_way_o),
        .flush_empty_i       (flush_empty_i)
    );

    // Directory contents
    logic [TAG_WIDTH-1:0] tag_mem   [NSETS][NWAYS];
    logic [NWAYS-1:0]     dirty_mem [NSETS];
    logic [NWAYS-1:0]     valid_mem [NSETS];

    // Stimulus knobs
    int gnt_pct = 100, rdy_pct = 100, empty_pct = 100;
    int gnt_hold = 0, rdy_hold = 0, empty_hold = 0;
    bit start_req = 0, start_noise = 0, walking = 0;
    bit rsp_pend = 0;
    int rsp_set = 0;

    // Scoreboard
    logic [NLW-1:0]   exp_nline_q [$];
    logic [NWAYS-1:0] exp_way_q   [$];
    int exp_total, exp_rd_set, n_alloc, done_cnt, done_step, cyc;
    logic [NLW-1:0] first_nline;
    bit prev_stall, prev_rd_stall;
    logic [NLW-1:0]   prev_nline;
    logic [NWAYS-1:0] prev_way;
    logic [SETW-1:0]  prev_rd_set;
    bit inval_mode = 0;
    int               inval_cyc_q [$];
    logic [NWAYS-1:0] inval_way_q [$];
    bit               inval_hs_q  [$];

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: every dirty line in set order, ways ascending within a set.
    task automatic build_expect();
        exp_nline_q.delete();
        exp_way_q.delete();
        for (int s = 0; s < NSETS; s++) begin
            for (int w = 0; w < NWAYS; w++) begin
                if (dirty_mem[s][w]) begin
                    exp_nline_q.push_back({tag_mem[s][w], SETW'(s)});
                    exp_way_q.push_back(NWAYS'(1) << w);
                end
            end
        end
        exp_total = exp_nline_q.size();
    endtask

    task automatic observe();
        logic hs;
        logic [NLW-1:0]   n;
        logic [NWAYS-1:0] w;
        cyc++;
        hs = flush_alloc_o && flush_alloc_ready_i;
        if (prev_stall) begin
            chk("alloc_hold_valid", flush_alloc_o, 1);
            chk("alloc_hold_nline", flush_alloc_nline_o, prev_nline);
            chk("alloc_hold_way", flush_alloc_way_o, prev_way);
        end
        if (prev_rd_stall) begin
            chk("rd_hold_valid", dir_rd_o, 1);
            chk("rd_hold_set", dir_rd_set_o, prev_rd_set);
        end
        prev_stall    = flush_alloc_o && !flush_alloc_ready_i;
        prev_nline    = flush_alloc_nline_o;
        prev_way      = flush_alloc_way_o;
        prev_rd_stall = dir_rd_o && !dir_gnt_i;
        prev_rd_set   = dir_rd_set_o;
        chk("clr_eq_handshake", dir_clr_o, hs);
        if (walking) chk("start_ready_busy", start_ready_o, 0);
        if (!flush_empty_i) chk("done_without_empty", done_o, 0);
`ifdef HPDCACHE_FLUSH_WALKER_INVAL_EN
        if (!inval_mode) chk("inval_eq_clr", dir_inval_o, hs);
        if (dir_inval_o) begin
            inval_cyc_q.push_back(cyc);
            inval_way_q.push_back(dir_clr_way_o);
            inval_hs_q.push_back(hs);
        end
`endif
        if (hs) begin
            if (exp_nline_q.size() == 0) begin
                chk("alloc_unexpected", flush_alloc_nline_o, '0);
            end else begin
                n = exp_nline_q.pop_front();
                w = exp_way_q.pop_front();
                chk("alloc_nline", flush_alloc_nline_o, n);
                chk("alloc_way", flush_alloc_way_o, w);
                chk("clr_set", dir_clr_set_o, n[SETW-1:0]);
                chk("clr_way", dir_clr_way_o, w);
                if (n_alloc == 0) first_nline = flush_alloc_nline_o;
                dirty_mem[n[SETW-1:0]] = dirty_mem[n[SETW-1:0]] & ~w;
            end
            n_alloc++;
        end
        if (dir_rd_o && dir_gnt_i) begin
            chk("rd_set_order", dir_rd_set_o, exp_rd_set);
            exp_rd_set++;
            rsp_pend = 1;
            rsp_set  = int'(dir_rd_set_o);
        end
        if (done_o) begin
            done_cnt++;
            done_step = cyc;
            chk("done_allocs_left", exp_nline_q.size(), 0);
            chk("done_reads", exp_rd_set, NSETS);
        end
    endtask

    // One clock: drive inputs after the falling edge, sample 1 time unit later.
    task automatic step();
        bit have_rsp;
        @(negedge clk_i);
        have_rsp = rsp_pend;
        rsp_pend = 0;
        start_i  = start_req || (start_noise && walking && ($urandom_range(0, 3) == 0));
        dir_gnt_i           = (cyc + 1 >= gnt_hold) && ($urandom_range(0, 99) < gnt_pct);
        flush_alloc_ready_i = (cyc + 1 >= rdy_hold) && ($urandom_range(0, 99) < rdy_pct);
        flush_empty_i       = (cyc + 1 >= empty_hold) && ($urandom_range(0, 99) < empty_pct);
        for (int w = 0; w < NWAYS; w++) begin
            dir_rd_tags_i[w*TAG_WIDTH +: TAG_WIDTH] = have_rsp ? tag_mem[rsp_set][w] : TAG_WIDTH'($urandom);
        end
        dir_rd_dirty_i = have_rsp ? dirty_mem[rsp_set] : NWAYS'($urandom);
`ifdef HPDCACHE_FLUSH_WALKER_INVAL_EN
        dir_rd_valid_i = have_rsp ? valid_mem[rsp_set] : NWAYS'($urandom);
`endif
        #1;
        observe();
    endtask

    task automatic start_walk();
        build_expect();
        exp_rd_set = 0; n_alloc = 0; done_cnt = 0; done_step = -1;
        first_nline = '0; prev_stall = 0; prev_rd_stall = 0;
        cyc = -1;
        start_req = 1;
        step();
        start_req = 0;
        chk("start_ready_idle", start_ready_o, 1);
        walking = 1;
    endtask

    task automatic finish_walk(input int budget);
        while (done_cnt == 0 && cyc < budget) step();
        chk("walk_done_seen", done_cnt, 1);
        walking = 0;
        step();
        chk("post_done_pulse", done_o, 0);
        chk("post_done_ready", start_ready_o, 1);
    endtask

    task automatic fill_tags_fixed();
        for (int s = 0; s < NSETS; s++) begin
            dirty_mem[s] = '0;
            valid_mem[s] = '0;
            for (int w = 0; w < NWAYS; w++) tag_mem[s][w] = TAG_WIDTH'(32'h1000 + s * 16 + w);
        end
        tag_mem[5][1] = 28'h123;
        tag_mem[5][6] = 28'h456;
    endtask

    typedef struct {
        int             set;
        logic [7:0]     mask;
        int             gnt_hold;
        int             rdy_hold;
        int             empty_hold;
        int             exp_allocs;
        int             exp_done;
        logic [NLW-1:0] exp_first;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{0,  8'h00, 0, 0,  0,   0, 193, '0};
        vecs[1] = '{5,  8'h42, 0, 0,  0,   2, 195, {28'h123, 6'd5}};
        vecs[2] = '{5,  8'h42, 0, 28, 0,   2, 205, {28'h123, 6'd5}};
        vecs[3] = '{0,  8'h00, 5, 0,  0,   0, 197, '0};
        vecs[4] = '{0,  8'h00, 0, 0,  213, 0, 213, '0};
        vecs[5] = '{63, 8'hFF, 0, 0,  0,   8, 201, {28'h13F0, 6'd63}};
        vecs[6] = '{0,  8'h80, 0, 0,  0,   1, 194, {28'h1007, 6'd0}};

        rst_ni = 0; start_i = 0; dir_gnt_i = 0; flush_alloc_ready_i = 0; flush_empty_i = 0;
        dir_rd_tags_i = '0; dir_rd_dirty_i = '0;
`ifdef HPDCACHE_FLUSH_WALKER_INVAL_EN
        dir_rd_valid_i = '0;
`endif
        cyc = 0;
        fill_tags_fixed();
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_start_ready", start_ready_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_rd", dir_rd_o, 0);
        chk("rst_alloc", flush_alloc_o, 0);
        chk("rst_clr", dir_clr_o, 0);
        chk("rst_nline", flush_alloc_nline_o, 0);
        chk("rst_rd_set", dir_rd_set_o, 0);
        rst_ni = 1;
        step();
        chk("idle_start_ready", start_ready_o, 1);

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            fill_tags_fixed();
            dirty_mem[vecs[i].set] = vecs[i].mask;
            valid_mem[vecs[i].set] = vecs[i].mask;
            gnt_pct = 100; rdy_pct = 100; empty_pct = 100;
            gnt_hold = vecs[i].gnt_hold; rdy_hold = vecs[i].rdy_hold; empty_hold = vecs[i].empty_hold;
            start_walk();
            finish_walk(2000);
            chk("vec_allocs", n_alloc, vecs[i].exp_allocs);
            chk("vec_done_cycle", done_step, vecs[i].exp_done);
            chk("vec_dir_clean", dirty_mem[vecs[i].set], 0);
            if (vecs[i].exp_allocs > 0) chk("vec_first_nline", first_nline, vecs[i].exp_first);
        end
        gnt_hold = 0; empty_hold = 0;

        // Reset while an alloc is stalled in ISSUE
        fill_tags_fixed();
        dirty_mem[0] = 8'h01;
        valid_mem[0] = 8'h01;
        rdy_hold = 100000;
        start_walk();
        for (int i = 0; i < 10 && !flush_alloc_o; i++) step();
        chk("rst_pre_alloc", flush_alloc_o, 1);
        @(negedge clk_i);
        rst_ni = 0;
        #1;
        chk("rst_mid_alloc", flush_alloc_o, 0);
        chk("rst_mid_way", flush_alloc_way_o, 0);
        chk("rst_mid_clr", dir_clr_o, 0);
        chk("rst_mid_ready", start_ready_o, 1);
        walking = 0; rsp_pend = 0; prev_stall = 0; prev_rd_stall = 0; rdy_hold = 0;
        @(negedge clk_i);
        rst_ni = 1;
        step();
        chk("rst_after_ready", start_ready_o, 1);
        chk("rst_after_rd", dir_rd_o, 0);
        chk("rst_after_dirty_kept", dirty_mem[0], 8'h01);

`ifdef HPDCACHE_FLUSH_WALKER_INVAL_EN
        // Set 3: valid 0x0F, dirty 0x01 -> alloc+inval way 0, then clean invalidates ways 1..3
        fill_tags_fixed();
        dirty_mem[3] = 8'h01;
        valid_mem[3] = 8'h0F;
        inval_mode = 1;
        inval_cyc_q.delete(); inval_way_q.delete(); inval_hs_q.delete();
        start_walk();
        finish_walk(2000);
        inval_mode = 0;
        chk("inval_allocs", n_alloc, 1);
        chk("inval_count", inval_way_q.size(), 4);
        chk("inval_done_cycle", done_step, 197);
        for (int i = 0; i < 4 && i < inval_way_q.size(); i++) begin
            chk("inval_way", inval_way_q[i], NWAYS'(1) << i);
            chk("inval_cycle", inval_cyc_q[i], inval_cyc_q[0] + i);
            chk("inval_with_alloc", inval_hs_q[i], (i == 0));
        end
`endif

        // Randomized walks against the expected-alloc list
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < NSETS; s++) begin
                dirty_mem[s] = NWAYS'($urandom & $urandom);
                valid_mem[s] = dirty_mem[s];
                for (int w = 0; w < NWAYS; w++) tag_mem[s][w] = TAG_WIDTH'($urandom);
            end
            gnt_pct = $urandom_range(50, 100);
            rdy_pct = $urandom_range(40, 100);
            empty_pct = 70;
            start_noise = 1;
            start_walk();
            finish_walk(5000);
            start_noise = 0;
            chk("rand_allocs", n_alloc, exp_total);
            for (int s = 0; s < NSETS; s++) chk("rand_dir_clean", dirty_mem[s], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
